// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM states, button indices
// and the counter-sizing helper.
package btn_pkg;

    localparam int unsigned NUM_BTN = 4;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_OK    = 2;
    localparam int BTN_BACK  = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } btn_state_e;

    // Largest of three timing parameters; sizes the per-channel counters.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with its own counter and,
// when RPT_EN is set, an auto-repeat timer that runs only while the button is held.
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 250_000,
    parameter int unsigned RPT_DELAY   = 12_500_000,
    parameter int unsigned RPT_PERIOD  = 2_500_000,
    parameter bit          ACTIVE_HIGH = 1'b1,
    parameter bit          RPT_EN      = 1'b0
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned CNT_MAX = max3(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed_c;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             press_c;
    logic             rpt_fire_c;

    // Polarity is fixed ahead of the synchronizer so the cleared flops read as released.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], raw_i ^ ~ACTIVE_HIGH};
    end

    assign pressed_c = sync_q[1];
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_c) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed_c) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    press_c = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_HELD: begin
                if (!pressed_c) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_REL_WAIT: begin
                // A return to pressed here is a release glitch: resume HELD silently.
                if (pressed_c) begin
                    state_d = ST_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pulse_d = press_c | rpt_fire_c;
    end

    if (RPT_EN) begin : g_rpt
        localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(RPT_DELAY - 1);
        localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(RPT_PERIOD - 1);

        logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             rpt_first_q, rpt_first_d;

        always_ff @(posedge vga_clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_first_q <= rpt_first_d;
            end
        end

        // Timer restarts on every fresh press and is frozen outside a steady HELD.
        always_comb begin
            rpt_cnt_d   = rpt_cnt_q;
            rpt_first_d = rpt_first_q;
            rpt_fire_c  = 1'b0;
            if (press_c) begin
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b1;
            end else if (state_q == ST_HELD && pressed_c) begin
                if (rpt_cnt_q == (rpt_first_q ? RPT_DLY_LAST : RPT_PER_LAST)) begin
                    rpt_fire_c  = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = (&rpt_cnt_q) ? rpt_cnt_q : rpt_cnt_q + CNT_W'(1);
                end
            end
        end
    end else begin : g_no_rpt
        assign rpt_fire_c = 1'b0;
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner for the game picture generator: debounced levels and press strobes
// for left/right/ok/back. Define BTN_AUTO_REPEAT_EN to add auto-repeat on left/right.
module btn_cond
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 250_000,
    parameter int unsigned RPT_DELAY   = 12_500_000,
    parameter int unsigned RPT_PERIOD  = 2_500_000,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
`ifdef BTN_AUTO_REPEAT_EN
        localparam bit RPT_EN = (i == BTN_LEFT) || (i == BTN_RIGHT);
`else
        localparam bit RPT_EN = 1'b0;
`endif
        btn_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .ACTIVE_HIGH(ACTIVE_HIGH),
            .RPT_EN     (RPT_EN)
        ) u_chan (
            .vga_clk(vga_clk),
            .rst_n  (rst_n),
            .raw_i  (btn_in[i]),
            .level_o(btn_level[i]),
            .pulse_o(btn_pulse[i])
        );
    end

endmodule
